// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_pkg
//  Description : Shared CPU definitions for the execute stage and the ALU
//                control decoder: ALU operation codes, forwarding select
//                codes, pipeline register layouts and the forwarding mux.
//  Revision    : 1.0  initial release
// ============================================================================
package ex_stage_pkg;

    // ALU control codes (ALU control decoder output encoding)
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_NOR = 4'b1100;

    // Forwarding select codes. 2'b11 is unused and falls back to the
    // ID/EX operand, which is the safe choice if the hazard unit glitches.
    localparam logic [1:0] c_FWD_IDEX  = 2'b00;
    localparam logic [1:0] c_FWD_WB    = 2'b01;
    localparam logic [1:0] c_FWD_EXMEM = 2'b10;

    // ID/EX pipeline register. An all-zero value is a bubble.
    typedef struct packed {
        logic        valid;
        logic [3:0]  alu_ctr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        alu_src;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
    } idex_t;

    // EX/MEM pipeline register.
    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        zero;
        logic        ovf;
        logic        branch_taken;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } exmem_t;

    // Operand forwarding mux shared by both ALU inputs.
    function automatic logic [31:0] fwd_sel(
        input logic [1:0]  sel,
        input logic [31:0] idex_val,
        input logic [31:0] exmem_val,
        input logic [31:0] wb_val
    );
        logic [31:0] v;
        v = idex_val;
        case (sel)
            c_FWD_EXMEM: v = exmem_val;
            c_FWD_WB:    v = wb_val;
            default:     v = idex_val;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational 32-bit ALU for the execute stage.
//  Ports       : a, b    in  32  operands
//                ctr     in  4   ALU control code (see ex_stage_pkg)
//                result  out 32  operation result (0 for undefined codes)
//                zero    out 1   result == 0
//                ovf     out 1   signed overflow of add/sub, else 0
//  Revision    : 1.0  initial release
// ============================================================================
module alu_core
    import ex_stage_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  ctr,
    output logic [31:0] result,
    output logic        zero,
    output logic        ovf
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_add_ovf;
    logic        w_sub_ovf;
    logic        w_slt;

    assign w_sum  = a + b;
    assign w_diff = a - b;

    // Add overflows when both operands share a sign the sum does not.
    assign w_add_ovf = (a[31] == b[31]) && (w_sum[31] != a[31]);
    // Subtract overflows when operand signs differ and the result sign
    // departs from the minuend.
    assign w_sub_ovf = (a[31] != b[31]) && (w_diff[31] != a[31]);

    assign w_slt = ($signed(a) < $signed(b));

    always_comb begin
        result = 32'd0;
        ovf    = 1'b0;
        case (ctr)
            c_ALU_ADD: begin
                result = w_sum;
                ovf    = w_add_ovf;
            end
            c_ALU_SUB: begin
                result = w_diff;
                ovf    = w_sub_ovf;
            end
            c_ALU_AND: result = a & b;
            c_ALU_OR:  result = a | b;
            c_ALU_SLT: result = {31'd0, w_slt};
            c_ALU_NOR: result = ~(a | b);
            default:   result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage of the 5-stage pipeline. Holds the ID/EX and
//                EX/MEM registers, the operand forwarding muxes and the
//                immediate select in front of alu_core. Latency from in_* to
//                out_* is two rising edges while hold is low.
//  Ports       : clk, reset (async, active-low), hold (freeze both regs),
//                flush (bubble into ID/EX)
//                in_*      decoded instruction from ID
//                fwd_a/b   forwarding selects, wb_data write-back value
//                out_*     EX/MEM register contents toward MEM
//  Revision    : 1.0  initial release
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        flush,

    input  logic        in_valid,
    input  logic [3:0]  in_aluCtr,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_imm,
    input  logic        in_aluSrc,
    input  logic [4:0]  in_rd,
    input  logic        in_regWrite,
    input  logic        in_memRead,
    input  logic        in_memWrite,
    input  logic        in_memToReg,
    input  logic        in_branch,

    input  logic [1:0]  fwd_a,
    input  logic [1:0]  fwd_b,
    input  logic [31:0] wb_data,

    output logic        out_valid,
    output logic [31:0] out_result,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_rd,
    output logic        out_zero,
    output logic        out_ovf,
    output logic        out_branch_taken,
    output logic        out_regWrite,
    output logic        out_memRead,
    output logic        out_memWrite,
    output logic        out_memToReg
);

    idex_t       r_idex;
    idex_t       w_idex_in;
    exmem_t      r_exmem;
    exmem_t      w_exmem_next;

    logic [31:0] w_op_a;
    logic [31:0] w_op_b_fwd;
    logic [31:0] w_op_b;
    logic [31:0] w_alu_result;
    logic        w_alu_zero;
    logic        w_alu_ovf;

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    always_comb begin
        w_idex_in            = '0;
        w_idex_in.valid      = in_valid;
        w_idex_in.alu_ctr    = in_aluCtr;
        w_idex_in.a          = in_a;
        w_idex_in.b          = in_b;
        w_idex_in.imm        = in_imm;
        w_idex_in.alu_src    = in_aluSrc;
        w_idex_in.rd         = in_rd;
        w_idex_in.reg_write  = in_regWrite;
        w_idex_in.mem_read   = in_memRead;
        w_idex_in.mem_write  = in_memWrite;
        w_idex_in.mem_to_reg = in_memToReg;
        w_idex_in.branch     = in_branch;
    end

    // hold wins over flush: a frozen pipeline must not lose its entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idex <= '0;
        end else if (!hold) begin
            r_idex <= flush ? idex_t'('0) : w_idex_in;
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding and ALU
    // ------------------------------------------------------------------
    // The EX/MEM path feeds back the result of the instruction one ahead.
    assign w_op_a     = fwd_sel(fwd_a, r_idex.a, r_exmem.result, wb_data);
    assign w_op_b_fwd = fwd_sel(fwd_b, r_idex.b, r_exmem.result, wb_data);

    // Stores need the register value even when the ALU uses the immediate
    // for address calculation, so store data taps before this mux.
    assign w_op_b = r_idex.alu_src ? r_idex.imm : w_op_b_fwd;

    alu_core u_alu (
        .a      (w_op_a),
        .b      (w_op_b),
        .ctr    (r_idex.alu_ctr),
        .result (w_alu_result),
        .zero   (w_alu_zero),
        .ovf    (w_alu_ovf)
    );

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    // Control outputs are gated with valid so that a bubble can never
    // write a register, touch memory or redirect fetch, whatever the ALU
    // happens to compute from forwarded data.
    always_comb begin
        w_exmem_next              = '0;
        w_exmem_next.valid        = r_idex.valid;
        w_exmem_next.result       = w_alu_result;
        w_exmem_next.store_data   = w_op_b_fwd;
        w_exmem_next.rd           = r_idex.rd;
        w_exmem_next.zero         = w_alu_zero;
        w_exmem_next.ovf          = w_alu_ovf;
        w_exmem_next.branch_taken = r_idex.valid & r_idex.branch & w_alu_zero;
        w_exmem_next.reg_write    = r_idex.valid & r_idex.reg_write;
        w_exmem_next.mem_read     = r_idex.valid & r_idex.mem_read;
        w_exmem_next.mem_write    = r_idex.valid & r_idex.mem_write;
        w_exmem_next.mem_to_reg   = r_idex.valid & r_idex.mem_to_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exmem <= '0;
        end else if (!hold) begin
            r_exmem <= w_exmem_next;
        end
    end

    assign out_valid        = r_exmem.valid;
    assign out_result       = r_exmem.result;
    assign out_store_data   = r_exmem.store_data;
    assign out_rd           = r_exmem.rd;
    assign out_zero         = r_exmem.zero;
    assign out_ovf          = r_exmem.ovf;
    assign out_branch_taken = r_exmem.branch_taken;
    assign out_regWrite     = r_exmem.reg_write;
    assign out_memRead      = r_exmem.mem_read;
    assign out_memWrite     = r_exmem.mem_write;
    assign out_memToReg     = r_exmem.mem_to_reg;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Self-checking bench for ex_stage. Directed scenarios plus a
//                randomized stream, compared every cycle against a
//                behavioural model of the two-deep execute pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold, flush;
    logic        in_valid;
    logic [3:0]  in_aluCtr;
    logic [31:0] in_a, in_b, in_imm;
    logic        in_aluSrc;
    logic [4:0]  in_rd;
    logic        in_regWrite, in_memRead, in_memWrite, in_memToReg, in_branch;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] wb_data;

    logic        out_valid;
    logic [31:0] out_result, out_store_data;
    logic [4:0]  out_rd;
    logic        out_zero, out_ovf, out_branch_taken;
    logic        out_regWrite, out_memRead, out_memWrite, out_memToReg;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk              (clk),
        .reset            (reset),
        .hold             (hold),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_aluCtr        (in_aluCtr),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_imm           (in_imm),
        .in_aluSrc        (in_aluSrc),
        .in_rd            (in_rd),
        .in_regWrite      (in_regWrite),
        .in_memRead       (in_memRead),
        .in_memWrite      (in_memWrite),
        .in_memToReg      (in_memToReg),
        .in_branch        (in_branch),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .wb_data          (wb_data),
        .out_valid        (out_valid),
        .out_result       (out_result),
        .out_store_data   (out_store_data),
        .out_rd           (out_rd),
        .out_zero         (out_zero),
        .out_ovf          (out_ovf),
        .out_branch_taken (out_branch_taken),
        .out_regWrite     (out_regWrite),
        .out_memRead      (out_memRead),
        .out_memWrite     (out_memWrite),
        .out_memToReg     (out_memToReg)
    );

    int n_vec = 0;
    int n_err = 0;

    localparam longint   c_SMAX  = 64'sd2147483647;
    localparam longint   c_SMIN  = -64'sd2147483648;
    localparam logic [3:0] c_CODES [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                                           4'b0111, 4'b1100, 4'b0011, 4'b1111};

    // Model: the instruction waiting in EX, and the expected outputs.
    logic        m_valid;
    logic [3:0]  m_ctr;
    logic [31:0] m_a, m_b, m_imm;
    logic        m_src;
    logic [4:0]  m_rd;
    logic [4:0]  m_ctl;   // {regWrite, memRead, memWrite, memToReg, branch}

    logic        e_valid;
    logic [31:0] e_result, e_store;
    logic [4:0]  e_rd;
    logic        e_zero, e_ovf, e_bt;
    logic [3:0]  e_ctl;   // {regWrite, memRead, memWrite, memToReg}

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Reference ALU from the arithmetic definitions.
    function automatic void alu_ref(input logic [3:0] ctr, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic o);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        r  = 32'd0;
        o  = 1'b0;
        case (ctr)
            4'b0010: begin s = sa + sb; r = s[31:0]; o = (s > c_SMAX) || (s < c_SMIN); end
            4'b0110: begin s = sa - sb; r = s[31:0]; o = (s > c_SMAX) || (s < c_SMIN); end
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            default: r = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] own,
                                         input logic [31:0] prev, input logic [31:0] wb);
        if (sel == 2'b10) return prev;
        if (sel == 2'b01) return wb;
        return own;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ctr = 0; m_a = 0; m_b = 0; m_imm = 0; m_src = 0; m_rd = 0; m_ctl = 0;
        e_valid = 0; e_result = 0; e_store = 0; e_rd = 0; e_zero = 0; e_ovf = 0; e_bt = 0;
        e_ctl = 0;
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_edge();
        logic [31:0] opa, fb, r;
        logic        o;
        if (!hold) begin
            opa = pick(fwd_a, m_a, e_result, wb_data);
            fb  = pick(fwd_b, m_b, e_result, wb_data);
            alu_ref(m_ctr, opa, m_src ? m_imm : fb, r, o);
            e_valid  = m_valid;
            e_result = r;
            e_zero   = (r == 32'd0);
            e_ovf    = o;
            e_store  = fb;
            e_rd     = m_rd;
            e_ctl    = m_valid ? m_ctl[4:1] : 4'd0;
            e_bt     = m_valid && m_ctl[0] && (r == 32'd0);
            if (flush) begin
                m_valid = 0; m_ctr = 0; m_a = 0; m_b = 0; m_imm = 0; m_src = 0;
                m_rd = 0; m_ctl = 0;
            end else begin
                m_valid = in_valid; m_ctr = in_aluCtr; m_a = in_a; m_b = in_b;
                m_imm = in_imm; m_src = in_aluSrc; m_rd = in_rd;
                m_ctl = {in_regWrite, in_memRead, in_memWrite, in_memToReg, in_branch};
            end
        end
    endtask

    task automatic compare_all();
        chk1("valid", out_valid, e_valid);
        chk1("regWrite", out_regWrite, e_ctl[3]);
        chk1("memRead", out_memRead, e_ctl[2]);
        chk1("memWrite", out_memWrite, e_ctl[1]);
        chk1("memToReg", out_memToReg, e_ctl[0]);
        chk1("branch_taken", out_branch_taken, e_bt);
        if (e_valid) begin
            chk32("result", out_result, e_result);
            chk32("store_data", out_store_data, e_store);
            chk32("rd", {27'd0, out_rd}, {27'd0, e_rd});
            chk1("zero", out_zero, e_zero);
            chk1("ovf", out_ovf, e_ovf);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk32({tag, "_bits"}, {out_valid, out_zero, out_ovf, out_branch_taken,
                               out_regWrite, out_memRead, out_memWrite, out_memToReg}, 32'd0);
        chk32({tag, "_result"}, out_result, 32'd0);
        chk32({tag, "_store"}, out_store_data, 32'd0);
        chk32({tag, "_rd"}, {27'd0, out_rd}, 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_in();
        hold = 0; flush = 0; in_valid = 0; in_aluCtr = 0; in_a = 0; in_b = 0; in_imm = 0;
        in_aluSrc = 0; in_rd = 0; in_regWrite = 0; in_memRead = 0; in_memWrite = 0;
        in_memToReg = 0; in_branch = 0; fwd_a = 0; fwd_b = 0; wb_data = 0;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_in();
        in_valid    = ($urandom_range(0, 3) != 0);
        in_aluCtr   = c_CODES[$urandom_range(0, 7)];
        in_a        = rand_word();
        in_b        = ($urandom_range(0, 3) == 0) ? in_a : rand_word();
        in_imm      = rand_word();
        in_aluSrc   = $urandom_range(0, 1) == 1;
        in_rd       = 5'($urandom);
        {in_regWrite, in_memRead, in_memWrite, in_memToReg, in_branch} = 5'($urandom);
        fwd_a       = 2'($urandom);
        fwd_b       = 2'($urandom);
        wb_data     = rand_word();
        hold        = ($urandom_range(0, 6) == 0);
        flush       = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        clear_in();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // ---------------- add 5+7 ----------------
        in_valid = 1; in_aluCtr = 4'b0010; in_a = 5; in_b = 7; in_rd = 3; in_regWrite = 1;
        cycle();
        clear_in();
        cycle();
        chk32("add_result", out_result, 32'd12);
        chk1("add_zero", out_zero, 1'b0);
        chk1("add_ovf", out_ovf, 1'b0);
        chk1("add_regWrite", out_regWrite, 1'b1);

        // ---------------- overflow then slt ----------------
        in_valid = 1; in_aluCtr = 4'b0010; in_a = 32'h7FFF_FFFF; in_b = 1;
        cycle();
        in_aluCtr = 4'b0111; in_a = 32'hFFFF_FFFF; in_b = 1;
        cycle();
        chk32("ovf_result", out_result, 32'h8000_0000);
        chk1("ovf_flag", out_ovf, 1'b1);
        clear_in();
        cycle();
        chk32("slt_result", out_result, 32'd1);

        // ---------------- branch, then flushed branch ----------------
        in_valid = 1; in_aluCtr = 4'b0110; in_a = 9; in_b = 9; in_branch = 1;
        cycle();
        clear_in();
        cycle();
        chk1("br_zero", out_zero, 1'b1);
        chk1("br_taken", out_branch_taken, 1'b1);
        in_valid = 1; in_aluCtr = 4'b0110; in_a = 9; in_b = 9; in_branch = 1; flush = 1;
        cycle();
        clear_in();
        cycle();
        chk1("flush_valid", out_valid, 1'b0);
        chk1("flush_taken", out_branch_taken, 1'b0);

        // ---------------- forwarding ----------------
        in_valid = 1; in_aluCtr = 4'b0010; in_a = 1; in_b = 2; in_regWrite = 1;
        cycle();
        in_a = 100; in_b = 4;
        cycle();
        clear_in();
        fwd_a = 2'b10;
        cycle();
        chk32("fwd_exmem", out_result, 32'd7);
        clear_in();
        in_valid = 1; in_aluCtr = 4'b0010; in_a = 0; in_b = 32'h55; in_imm = 32'h9;
        cycle();
        clear_in();
        fwd_b = 2'b01; wb_data = 32'h100;
        cycle();
        chk32("fwd_wb_store", out_store_data, 32'h100);
        chk32("fwd_wb_result", out_result, 32'h100);

        // ---------------- hold mid-stream ----------------
        clear_in();
        for (int i = 0; i < 4; i++) begin
            rand_in(); hold = 0; flush = 0; in_valid = 1;
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            rand_in(); hold = 1;
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            rand_in(); hold = 0; flush = 0;
            cycle();
        end

        // ---------------- randomized stream ----------------
        for (int i = 0; i < 400; i++) begin
            rand_in();
            cycle();
        end

        // ---------------- async reset pulse mid-stream ----------------
        rand_in(); hold = 0; flush = 0; in_valid = 1;
        cycle();
        cycle();
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        clear_in();
        #2;
        reset = 1'b1;

        // first valid output two edges after the first accepted entry
        in_valid = 1; in_aluCtr = 4'b0010; in_a = 2; in_b = 3; in_rd = 1; in_regWrite = 1;
        cycle();
        chk1("post_reset_lat1", out_valid, 1'b0);
        clear_in();
        cycle();
        chk1("post_reset_lat2", out_valid, 1'b1);
        chk32("post_reset_result", out_result, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-003 SHALL have: hold  in  1  whole-pipeline freeze.
REQ-004 SHALL have: flush  in  1  bubble into the ID/EX register.
REQ-005 SHALL have: in_valid  in  1; in_aluCtr  in  4  (ALU control decoder output); in_a, in_b  in  32  register-file operands.
REQ-006 SHALL have: in_imm  in  32; in_aluSrc  in  1  (1 selects in_imm as operand B); in_rd  in  5.
REQ-007 SHALL have: in_regWrite, in_memRead, in_memWrite, in_memToReg, in_branch  in  1 each.
REQ-008 SHALL have: fwd_a, fwd_b  in  2  (00 ID/EX operand, 10 EX/MEM result, 01 wb_data); wb_data  in  32.
REQ-009 SHALL have: out_valid  out 1; out_result  out 32; out_store_data  out 32; out_rd  out 5; out_zero, out_ovf, out_branch_taken  out 1.
REQ-010 SHALL have: out_regWrite, out_memRead, out_memWrite, out_memToReg  out 1 each.

Function
REQ-011 SHALL contain two registers: ID/EX (captures in_*) and EX/MEM (drives all out_*); in_* to out_* latency is exactly 2 cycles with hold low.
REQ-012 ID/EX SHALL load in_* on an edge when hold=0 and flush=0.
REQ-013 On flush=1 with hold=0, ID/EX SHALL load a bubble: valid=0, all five control bits 0, aluCtr=0000, data fields 0.
REQ-014 On hold=1, both registers SHALL keep their contents, flush ignored that edge.
REQ-015 Operand A SHALL be chosen by fwd_a from ID/EX a, EX/MEM out_result, or wb_data; fwd_b likewise for B before the aluSrc mux; fwd code 11 SHALL select the ID/EX operand.
REQ-016 out_store_data SHALL be the forwarded B operand, before the aluSrc mux.
REQ-017 ALU: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 signed set-less-than (1 or 0), 1100 nor; any other code result 0.
REQ-018 Arithmetic SHALL be 32-bit modulo 2^32; ovf=1 only on signed overflow of add/sub, else 0; zero = (result == 0).
REQ-019 EX/MEM SHALL load every edge with hold=0: result, flags, rd, control, valid.
REQ-020 out_branch_taken SHALL be ID/EX branch AND zero AND valid, registered.
REQ-021 A bubble (valid=0) SHALL propagate with all control outputs 0 regardless of ALU result.

Reset
REQ-022 On reset low every register SHALL clear to 0: out_valid=0, all out_* 0, ID/EX bubble.
REQ-023 Reset asserted mid-operation SHALL discard both in-flight entries; first valid output after release SHALL appear 2 edges after first accepted in_valid.

Structure
REQ-024 ALU control codes (ADD, SUB, AND, OR, SLT, NOR) and forwarding select codes SHALL be constants in the shared CPU package, also used by the ALU control decoder.
REQ-025 The combinational ALU SHALL be one sub-module alu_core (a, b, ctr -> result, zero, ovf); the registers and muxes stay in ex_stage.

Verification
REQ-026 add: in_a=5, in_b=7, aluCtr=0010, regWrite=1 -> 2 edges later out_result=12, zero=0, ovf=0, out_regWrite=1.
REQ-027 overflow/slt: 0x7FFFFFFF+1 (0010) -> out_result=0x80000000, ovf=1; slt a=-1, b=1 (0111) -> result=1.
REQ-028 branch: sub a=b=9, branch=1 -> out_zero=1, out_branch_taken=1; same with flush on capture edge -> out_valid=0, branch_taken=0.
REQ-029 forwarding: back-to-back add then add with fwd_a=10 -> second uses first result; fwd_b=01, wb_data=0x100, aluSrc=0 -> out_store_data=0x100.
REQ-030 hold 3 cycles mid-stream -> outputs frozen, no entry lost or duplicated; reset pulse mid-stream -> all outputs 0 immediately, async of clk.
